// File: rtl/stopwatch_counter_pkg.sv
// Shared stopwatch definitions: digit width, digit maxima and default clock rates.
package stopwatch_counter_pkg;

  localparam int DIGIT_W     = 4;
  localparam int MAX9        = 9;
  localparam int MAX5        = 5;
  localparam int CLK_HZ_DEF  = 100_000_000;
  localparam int TICK_HZ_DEF = 100;

  typedef logic [DIGIT_W-1:0] digit_t;

endpackage

// File: rtl/stopwatch_counter_bcd_digit.sv
// One BCD digit of the time chain: counts 0..MAX when its carry-in is high,
// wraps to 0 and raises a combinational carry-out on the wrapping increment.
module bcd_digit
  import stopwatch_counter_pkg::*;
#(
  parameter int MAX = MAX9
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   clear,
  input  logic   inc,
  output digit_t q,
  output logic   carry
);

  digit_t q_q;
  digit_t q_d;
  logic   at_max;

  assign at_max = (q_q == DIGIT_W'(MAX));
  assign carry  = inc && at_max;
  assign q      = q_q;

  // Next digit value: hold, increment, or wrap to zero at MAX.
  always_comb begin
    // NOTE: default assignment first, so every path drives q_d and no latch is inferred.
    q_d = q_q;
    if (inc) begin
      q_d = at_max ? '0 : q_q + DIGIT_W'(1);
    end
  end

  // Digit register; clear overrides any increment due on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) begin
      q_q <= '0;
    end else if (clear) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch timekeeping datapath: a prescaler turns enabled clock edges into
// hundredth-of-a-second advances that ripple through a MM:SS.cc BCD chain.
module stopwatch_counter
  import stopwatch_counter_pkg::*;
#(
  parameter int CLK_HZ  = CLK_HZ_DEF,
  parameter int TICK_HZ = TICK_HZ_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   enable,
  input  logic   clear,
  output digit_t cs_ones,
  output digit_t cs_tens,
  output digit_t s_ones,
  output digit_t s_tens,
  output digit_t m_ones,
  output digit_t m_tens,
  output logic   tick,
  output logic   rollover
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);

  if (DIV < 2 || (CLK_HZ % TICK_HZ) != 0) begin : g_bad_div
    $error("stopwatch_counter: CLK_HZ/TICK_HZ must be an integer >= 2");
  end

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic          advance;
  logic          tick_q;
  logic          tick_d;
  logic          rollover_q;
  logic          rollover_d;

  // Carries between digits; c_m_tens is the wrap of the whole display.
  logic c_cs_ones;
  logic c_cs_tens;
  logic c_s_ones;
  logic c_s_tens;
  logic c_m_ones;
  logic c_m_tens;

  assign advance = enable && (presc_q == PW'(DIV - 1));

  // Prescaler next state: clear wins, pause holds the partial tick.
  always_comb begin
    presc_d    = presc_q;
    tick_d     = advance && !clear;
    rollover_d = c_m_tens && !clear;
    if (clear) begin
      presc_d = '0;
    end else if (enable) begin
      presc_d = advance ? '0 : presc_q + PW'(1);
    end
  end

  // Prescaler and one-cycle tick/rollover pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= '0;
      tick_q     <= 1'b0;
      rollover_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      rollover_q <= rollover_d;
    end
  end

  bcd_digit #(.MAX(MAX9)) u_cs_ones (
    .clk(clk), .rst(rst), .clear(clear), .inc(advance),
    .q(cs_ones), .carry(c_cs_ones)
  );

  bcd_digit #(.MAX(MAX9)) u_cs_tens (
    .clk(clk), .rst(rst), .clear(clear), .inc(c_cs_ones),
    .q(cs_tens), .carry(c_cs_tens)
  );

  bcd_digit #(.MAX(MAX9)) u_s_ones (
    .clk(clk), .rst(rst), .clear(clear), .inc(c_cs_tens),
    .q(s_ones), .carry(c_s_ones)
  );

  bcd_digit #(.MAX(MAX5)) u_s_tens (
    .clk(clk), .rst(rst), .clear(clear), .inc(c_s_ones),
    .q(s_tens), .carry(c_s_tens)
  );

  bcd_digit #(.MAX(MAX9)) u_m_ones (
    .clk(clk), .rst(rst), .clear(clear), .inc(c_s_tens),
    .q(m_ones), .carry(c_m_ones)
  );

  bcd_digit #(.MAX(MAX5)) u_m_tens (
    .clk(clk), .rst(rst), .clear(clear), .inc(c_m_ones),
    .q(m_tens), .carry(c_m_tens)
  );

  assign tick     = tick_q;
  assign rollover = rollover_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench for stopwatch_counter at CLK_HZ=1000, TICK_HZ=100 (DIV=10).
// A model tracks elapsed hundredths as one integer and derives the digits arithmetically.
module tb_stopwatch_counter;

  localparam int DIV  = 10;
  localparam int WRAP = 60 * 60 * 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens;
  logic       tick, rollover;
  logic [23:0] disp;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state.
  int   m_part  = 0;
  int   m_total = 0;
  logic m_tick  = 1'b0;
  logic m_roll  = 1'b0;
  logic load_req = 1'b0;
  int   load_val = 0;
  logic cmp_on   = 1'b0;
  logic [23:0] pre_b;

  stopwatch_counter #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .cs_ones(cs_ones), .cs_tens(cs_tens), .s_ones(s_ones), .s_tens(s_tens),
    .m_ones(m_ones), .m_tens(m_tens), .tick(tick), .rollover(rollover)
  );

  assign disp = {m_tens, m_ones, s_tens, s_ones, cs_tens, cs_ones};

  always #5 clk = ~clk;

  function automatic logic [23:0] to_bcd(input int t);
    int cs, s, m;
    cs = t % 100;
    s  = (t / 100) % 60;
    m  = t / 6000;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: every enabled edge adds one to a partial count; each DIV-th adds a hundredth.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_part <= 0; m_total <= 0; m_tick <= 1'b0; m_roll <= 1'b0;
    end else if (clear) begin
      m_part <= 0; m_total <= 0; m_tick <= 1'b0; m_roll <= 1'b0;
    end else if (load_req) begin
      m_total <= load_val; m_tick <= 1'b0; m_roll <= 1'b0;
    end else if (enable && m_part == DIV - 1) begin
      m_part  <= 0;
      m_total <= (m_total + 1) % WRAP;
      m_tick  <= 1'b1;
      m_roll  <= (m_total == WRAP - 1);
    end else begin
      if (enable) m_part <= m_part + 1;
      m_tick <= 1'b0;
      m_roll <= 1'b0;
    end
  end

  // Compare process: outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (cmp_on && !rst) begin
      check("model_disp", 32'(disp), 32'(to_bcd(m_total)));
      check("model_tick", 32'(tick), 32'(m_tick));
      check("model_rollover", 32'(rollover), 32'(m_roll));
    end
  end

  // One clock: inputs held across the next rising edge, return 2 time units after it.
  task automatic cyc(input logic en, input logic clr);
    enable = en;
    clear  = clr;
    @(posedge clk);
    #2;
  endtask

  task automatic run(input logic en, input int ncyc, output int nt, output int first,
                     output int bad_gap);
    int last;
    nt = 0; first = -1; bad_gap = 0; last = -1;
    for (int i = 1; i <= ncyc; i++) begin
      cyc(en, 1'b0);
      if (tick === 1'b1) begin
        nt++;
        if (first < 0) first = i;
        if (last >= 0 && (i - last) != DIV) bad_gap++;
        last = i;
      end
    end
  endtask

  // Enabled edges until the first tick; -1 if none within the budget.
  task automatic edges_to_tick(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      cyc(1'b1, 1'b0);
      if (tick === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Deposit a time value into the digit registers while paused.
  task automatic preload(input int t);
    cmp_on = 1'b0;
    pre_b  = to_bcd(t);
    force dut.u_m_tens.q_q  = pre_b[23:20];
    force dut.u_m_ones.q_q  = pre_b[19:16];
    force dut.u_s_tens.q_q  = pre_b[15:12];
    force dut.u_s_ones.q_q  = pre_b[11:8];
    force dut.u_cs_tens.q_q = pre_b[7:4];
    force dut.u_cs_ones.q_q = pre_b[3:0];
    #1;
    release dut.u_m_tens.q_q;
    release dut.u_m_ones.q_q;
    release dut.u_s_tens.q_q;
    release dut.u_s_ones.q_q;
    release dut.u_cs_tens.q_q;
    release dut.u_cs_ones.q_q;
    load_val = t;
    load_req = 1'b1;
    cyc(1'b0, 1'b0);
    load_req = 1'b0;
    cmp_on   = 1'b1;
  endtask

  initial begin
    int nt, first, bad, n;

    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    check("reset_disp", 32'(disp), 32'h0);
    check("reset_tick", 32'(tick), 32'h0);
    check("reset_rollover", 32'(rollover), 32'h0);
    cmp_on = 1'b1;

    // Reset mid-run at 00:03.47 with a partial tick pending.
    cyc(1'b0, 1'b1);
    run(1'b1, 3475, nt, first, bad);
    check("pre_reset_disp", 32'(disp), 32'h000347);
    #1 rst = 1'b1;
    #1;
    check("async_reset_disp", 32'(disp), 32'h0);
    check("async_reset_tick", 32'(tick), 32'h0);
    rst = 1'b0;
    edges_to_tick(n);
    check("post_reset_first_tick", 32'(n), 32'd10);

    // Basic count: 100 enabled cycles from clear.
    cyc(1'b0, 1'b1);
    run(1'b1, 100, nt, first, bad);
    check("basic_tick_count", 32'(nt), 32'd10);
    check("basic_first_tick", 32'(first), 32'd10);
    check("basic_bad_gaps", 32'(bad), 32'd0);
    check("basic_disp", 32'(disp), 32'h000010);

    // Pause/resume: 15 on, 50 off, 5 on.
    cyc(1'b0, 1'b1);
    run(1'b1, 15, nt, first, bad);
    check("pause_phase1_ticks", 32'(nt), 32'd1);
    run(1'b0, 50, nt, first, bad);
    check("pause_paused_ticks", 32'(nt), 32'd0);
    run(1'b1, 5, nt, first, bad);
    check("pause_resume_ticks", 32'(nt), 32'd1);
    check("pause_resume_edge", 32'(first), 32'd5);
    check("pause_disp", 32'(disp), 32'h000002);

    // Cascade into the seconds tens digit by real counting.
    cyc(1'b0, 1'b1);
    run(1'b1, 9990, nt, first, bad);
    check("cascade1_pre", 32'(disp), 32'h000999);
    run(1'b1, 10, nt, first, bad);
    check("cascade1_disp", 32'(disp), 32'h001000);
    check("cascade1_tick", 32'(tick), 32'h1);

    // Cascade into the minutes tens digit.
    cyc(1'b0, 1'b1);
    preload(59999);
    check("cascade2_pre", 32'(disp), 32'h095999);
    run(1'b1, 10, nt, first, bad);
    check("cascade2_disp", 32'(disp), 32'h100000);

    // Wrap from 59:59.99.
    cyc(1'b0, 1'b1);
    preload(WRAP - 1);
    check("wrap_pre", 32'(disp), 32'h595999);
    run(1'b1, 9, nt, first, bad);
    check("wrap_no_early_tick", 32'(nt), 32'd0);
    cyc(1'b1, 1'b0);
    check("wrap_disp", 32'(disp), 32'h0);
    check("wrap_tick", 32'(tick), 32'h1);
    check("wrap_rollover", 32'(rollover), 32'h1);
    cyc(1'b1, 1'b0);
    check("wrap_tick_after", 32'(tick), 32'h0);
    check("wrap_rollover_after", 32'(rollover), 32'h0);

    // Clear colliding with the terminal-count edge.
    cyc(1'b0, 1'b1);
    run(1'b1, 19, nt, first, bad);
    check("collide_pre", 32'(disp), 32'h000001);
    cyc(1'b1, 1'b1);
    check("collide_disp", 32'(disp), 32'h0);
    check("collide_tick", 32'(tick), 32'h0);
    edges_to_tick(n);
    check("collide_next_tick", 32'(n), 32'd10);

    // Randomized traffic near the wrap point, with sporadic clears and resets.
    cyc(1'b0, 1'b1);
    preload(WRAP - 50);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) == 0));
    end

    cmp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Timekeeping datapath driven by the stopwatch run/pause controller's `enable` output. A clock prescaler produces hundredth-of-a-second ticks. Those ticks advance a six-digit BCD time value, MM:SS.cc, from 00:00.00 to 59:59.99. The digit outputs feed the display multiplexer.

## Interface
- `CLK_HZ`, default 100_000_000: input clock frequency.
- `TICK_HZ`, default 100: count rate. `DIV = CLK_HZ/TICK_HZ` must be an integer ≥ 2.
- `clk`  in  1: system clock. Single clock domain.
- `rst`  in  1: reset, asynchronous and active-high. Clears all state.
- `enable`  in  1: count permission from the run/pause controller. Level-sensitive.
- `clear`  in  1: synchronous zero request, e.g. a lap/reset button pulse.
- `cs_ones`, `cs_tens`  out  4 each: hundredths digits, BCD.
- `s_ones`  out  4: seconds units, range 0-9.
- `s_tens`  out  4: seconds tens, range 0-5.
- `m_ones`  out  4: minutes units, range 0-9.
- `m_tens`  out  4: minutes tens, range 0-5.
- `tick`  out  1: one-cycle pulse, high in the cycle the digits show a newly incremented value.
- `rollover`  out  1: one-cycle pulse, coincident with `tick`, when the value wraps 59:59.99 → 00:00.00.

## Operation
- Prescaler `presc` has width clog2(DIV).
  - It counts 0..DIV-1 on every edge with `enable`=1.
  - At DIV-1 it returns to 0 and issues an advance.
  - While `enable`=0 it holds its value. A pause therefore preserves the partial tick, and resume continues from that point.
- Digit chain: ripple-carry of BCD digits, all updated on the same edge.
  - `cs_ones` advances 9→0 with carry out.
  - `cs_tens` advances 9→0 with carry out.
  - `s_ones` advances 9→0 with carry out.
  - `s_tens` advances 5→0 with carry out.
  - `m_ones` advances 9→0 with carry out.
  - `m_tens` advances 5→0. Its carry out is the rollover.
  - A digit increments only when its carry-in is high. No digit ever holds a value outside its range.
- Wrap-around: from 59:59.99 the next advance yields 00:00.00 and asserts `rollover`. Counting continues; it does not saturate.
- `clear` has priority over `enable`. When it is sampled high:
  - `presc` and all digits go to 0 on that edge.
  - `tick` and `rollover` are 0 in the following cycle.
  - An advance due on that same edge is discarded.
- `enable` and `clear` are both high: clear wins. Counting resumes from `presc`=0 on the next enabled edge.
- `enable` toggling on the terminal-count edge: the advance occurs only if `enable`=1 at that edge.
- Reset values:
  - `presc`=0.
  - All digits 0, so the display reads 00:00.00.
  - `tick`=0 and `rollover`=0.
- Reset mid-count: state is forced to the reset values immediately and asynchronously. There is no partial-tick memory after reset.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Latency from clear: after `clear` (or reset release), the first advance occurs on the DIV-th enabled edge.
  - New digits and `tick`=1 are visible in the cycle after that edge.
- `tick` and `rollover` are high for exactly one cycle.
- Advances are at least DIV cycles apart, so `tick` never asserts in consecutive cycles.
- Pause latency: `enable` falling before edge N means edge N does not advance the prescaler.
- The counter does not gate or delay `enable`. The controller's registered `enable` is consumed directly.

## Structure
- Shared stopwatch definitions header holds:
  - `DIGIT_W`=4
  - digit maxima `MAX9`=9 and `MAX5`=5
  - default `CLK_HZ` and `TICK_HZ`.
- Sub-module `bcd_digit`, instanced six times in a carry chain:
  - Parameter `MAX`.
  - Ports `clk`, `rst`, `clear`, `inc`, `q[3:0]`, `carry`.
  - `carry` = `inc` && `q`==`MAX`, combinational.
- The top level holds the prescaler, the carry chain, and the `tick`/`rollover` registers.

## Test plan
All scenarios use `CLK_HZ`=1000 and `TICK_HZ`=100, so DIV=10.
- Reset: `rst` pulse mid-run at value 00:03.47 → all digits 0 and `presc`=0 immediately; `tick`=0.
- Basic count: `enable` held high from clear for 100 cycles → exactly 10 `tick` pulses; display 00:00.10; each `tick` lands 10 cycles after the previous one.
- Pause/resume: enable for 15 cycles, disable for 50, enable for 5 → display 00:00.02; second `tick` occurs on the 20th enabled edge; no `tick` while paused.
- Cascades:
  - Preload by counting to 00:09.99, then one advance → 00:10.00.
  - From 09:59.99, one advance → 10:00.00.
- Wrap: from 59:59.99, one advance → 00:00.00 with `tick`=1 and `rollover`=1 in the same cycle, both low the next cycle.
- Clear collision: `clear`=1 and `enable`=1 on the edge where `presc`=9 → display 00:00.00, `tick`=0; next `tick` arrives 10 enabled edges later.
